// File: rtl/cc_mem_arbiter_if.sv
// Memory-refill bus between the I-cache/D-cache controllers, the arbiter and memory.
//   master : arbiter view (takes cache requests and memory data, drives acks and memory request)
//   slave  : environment view (cache controllers and memory)
// Ports (all plain logic):
//   req/adr_{ic,dc}2arb      cache refill request and miss address
//   ack/dat/word/last/err_arb2{ic,dc}  returned words to each cache
//   req/adr_arb2mem          memory read request and beat word address
//   ack/dat_mem2arb          memory data valid and data
interface cc_mem_arbiter_if #(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WORD_OFFSET = 2
);
    logic                   req_ic2arb;
    logic [ADR_WIDTH-1:0]   adr_ic2arb;
    logic                   ack_arb2ic;
    logic [DATA_WIDTH-1:0]  dat_arb2ic;
    logic [WORD_OFFSET-1:0] word_arb2ic;
    logic                   last_arb2ic;
    logic                   err_arb2ic;

    logic                   req_dc2arb;
    logic [ADR_WIDTH-1:0]   adr_dc2arb;
    logic                   ack_arb2dc;
    logic [DATA_WIDTH-1:0]  dat_arb2dc;
    logic [WORD_OFFSET-1:0] word_arb2dc;
    logic                   last_arb2dc;
    logic                   err_arb2dc;

    logic                   req_arb2mem;
    logic [ADR_WIDTH-1:0]   adr_arb2mem;
    logic                   ack_mem2arb;
    logic [DATA_WIDTH-1:0]  dat_mem2arb;

    modport master (
        input  req_ic2arb, adr_ic2arb, req_dc2arb, adr_dc2arb, ack_mem2arb, dat_mem2arb,
        output ack_arb2ic, dat_arb2ic, word_arb2ic, last_arb2ic, err_arb2ic,
        output ack_arb2dc, dat_arb2dc, word_arb2dc, last_arb2dc, err_arb2dc,
        output req_arb2mem, adr_arb2mem
    );

    modport slave (
        output req_ic2arb, adr_ic2arb, req_dc2arb, adr_dc2arb, ack_mem2arb, dat_mem2arb,
        input  ack_arb2ic, dat_arb2ic, word_arb2ic, last_arb2ic, err_arb2ic,
        input  ack_arb2dc, dat_arb2dc, word_arb2dc, last_arb2dc, err_arb2dc,
        input  req_arb2mem, adr_arb2mem
    );
endinterface

// File: rtl/cc_mem_arbiter.sv
// Round-robin arbiter sharing the memory refill port between the I-cache and D-cache.
// Grants one cache at a time and sequences a 2**WORD_OFFSET word line burst, returning
// each word (registered, one cycle after the memory ack) with its index within the line.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       cc_mem_arbiter_if.master (cache request/return sets and memory port)
// Optional feature: define ARB_TIMEOUT_EN to abort a burst after TIMEOUT_CYC cycles
// without a memory ack; the owner then sees a one-cycle err pulse.
module cc_mem_arbiter #(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WORD_OFFSET = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    cc_mem_arbiter_if.master bus
);
    localparam int unsigned BASE_LSB  = WORD_OFFSET + 2;
    localparam int unsigned LAST_WORD = (1 << WORD_OFFSET) - 1;
    localparam logic        OWN_IC    = 1'b0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REL} state_e;

    state_e                             state_q;
    logic                               owner_q;     // 0: IC, 1: DC
    logic                               rr_q;        // 1: DC wins a tie
    logic [ADR_WIDTH-1:0]               base_q;
    logic [ADR_WIDTH-1:0]               adr_mem_q;
    logic                               req_mem_q;
    logic [WORD_OFFSET-1:0]             word_cnt_q;
    logic [1:0]                         ack_q;
    logic [1:0]                         last_q;
    logic [1:0][DATA_WIDTH-1:0]         dat_q;
    logic [1:0][WORD_OFFSET-1:0]        word_q;

    logic                               any_req_d;
    logic                               grant_dc_d;
    logic                               owner_req_d;
    logic                               last_beat_d;
    logic [ADR_WIDTH-1:0]               base_d;
    logic [ADR_WIDTH-1:0]               adr_nxt_d;
    logic [WORD_OFFSET-1:0]             word_nxt_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [1:0]                         err_q;
    logic [TO_W-1:0]                    to_cnt_q;
`else
    logic                               unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

    // Line-offset address bits are replaced by the beat counter
    logic unused_adr;
    assign unused_adr = ^{bus.adr_ic2arb[BASE_LSB-1:0], bus.adr_dc2arb[BASE_LSB-1:0]};

    // Grant selection: a tie is resolved by the round-robin pointer
    always_comb begin
        any_req_d  = bus.req_ic2arb | bus.req_dc2arb;
        grant_dc_d = bus.req_dc2arb;
        if (bus.req_ic2arb && bus.req_dc2arb) begin
            grant_dc_d = rr_q;
        end
        base_d = grant_dc_d ? {bus.adr_dc2arb[ADR_WIDTH-1:BASE_LSB], BASE_LSB'(0)}
                            : {bus.adr_ic2arb[ADR_WIDTH-1:BASE_LSB], BASE_LSB'(0)};
        owner_req_d = (owner_q == OWN_IC) ? bus.req_ic2arb : bus.req_dc2arb;
        last_beat_d = (word_cnt_q == WORD_OFFSET'(LAST_WORD));
        word_nxt_d  = word_cnt_q + 1'b1;
        adr_nxt_d   = base_q | (ADR_WIDTH'(word_nxt_d) << 2);
    end

    // Arbitration and burst sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IC;
            rr_q       <= 1'b0;
            base_q     <= '0;
            adr_mem_q  <= '0;
            req_mem_q  <= 1'b0;
            word_cnt_q <= '0;
            ack_q      <= '0;
            last_q     <= '0;
            dat_q      <= '0;
            word_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q      <= '0;
            to_cnt_q   <= '0;
`endif
        end else begin
            // Return signals are single-cycle pulses
            ack_q  <= '0;
            last_q <= '0;
            dat_q  <= '0;
            word_q <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        owner_q    <= grant_dc_d;
                        rr_q       <= ~grant_dc_d;
                        base_q     <= base_d;
                        adr_mem_q  <= base_d;
                        req_mem_q  <= 1'b1;
                        word_cnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.ack_mem2arb) begin
                        ack_q[owner_q]  <= 1'b1;
                        dat_q[owner_q]  <= bus.dat_mem2arb;
                        word_q[owner_q] <= word_cnt_q;
                        last_q[owner_q] <= last_beat_d;
`ifdef ARB_TIMEOUT_EN
                        to_cnt_q        <= '0;
`endif
                        if (last_beat_d) begin
                            req_mem_q  <= 1'b0;
                            adr_mem_q  <= '0;
                            word_cnt_q <= '0;
                            state_q    <= S_REL;
                        end else begin
                            word_cnt_q <= word_nxt_d;
                            adr_mem_q  <= adr_nxt_d;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        err_q[owner_q] <= 1'b1;
                        req_mem_q      <= 1'b0;
                        adr_mem_q      <= '0;
                        word_cnt_q     <= '0;
                        to_cnt_q       <= '0;
                        state_q        <= S_REL;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                // Hold off until the owner releases so a stale request is not re-granted
                S_REL: begin
                    if (!owner_req_d) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_arb2mem = req_mem_q;
    assign bus.adr_arb2mem = adr_mem_q;
    assign bus.ack_arb2ic  = ack_q[0];
    assign bus.dat_arb2ic  = dat_q[0];
    assign bus.word_arb2ic = word_q[0];
    assign bus.last_arb2ic = last_q[0];
    assign bus.ack_arb2dc  = ack_q[1];
    assign bus.dat_arb2dc  = dat_q[1];
    assign bus.word_arb2dc = word_q[1];
    assign bus.last_arb2dc = last_q[1];
`ifdef ARB_TIMEOUT_EN
    assign bus.err_arb2ic  = err_q[0];
    assign bus.err_arb2dc  = err_q[1];
`else
    assign bus.err_arb2ic  = 1'b0;
    assign bus.err_arb2dc  = 1'b0;
`endif
endmodule

// File: tb/tb_cc_mem_arbiter.sv
// Testbench for cc_mem_arbiter: a randomized memory model feeds the arbiter while a
// monitor collects returned words; each scenario compares against line-burst rules.
module tb_cc_mem_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned WO    = 2;
    localparam int          NBEAT = 4;

    typedef struct packed {
        logic [WO-1:0] word;
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    logic clk;
    logic rst;

    cc_mem_arbiter_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO)) bus ();

    cc_mem_arbiter #(
        .ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t       ic_obs[$];
    beat_t       dc_obs[$];
    logic [31:0] mem_adr[$];
    logic [31:0] mem_dat[$];
    int ic_active, dc_active, ic_err, dc_err;

    bit mem_en, mem_alt, mem_fixed, mem_spurious, alt_phase;
    int ack_pct;

    // One cycle: sample outputs at negedge, then drive the memory side for the next edge
    task automatic tick();
        beat_t b;
        bit    go;
        logic [31:0] d;
        @(negedge clk);
        if (bus.ack_arb2ic) begin
            b.word = bus.word_arb2ic; b.dat = bus.dat_arb2ic; b.last = bus.last_arb2ic;
            ic_obs.push_back(b);
        end
        if (bus.ack_arb2dc) begin
            b.word = bus.word_arb2dc; b.dat = bus.dat_arb2dc; b.last = bus.last_arb2dc;
            dc_obs.push_back(b);
        end
        if (|{bus.ack_arb2ic, bus.dat_arb2ic, bus.word_arb2ic, bus.last_arb2ic, bus.err_arb2ic}) ic_active++;
        if (|{bus.ack_arb2dc, bus.dat_arb2dc, bus.word_arb2dc, bus.last_arb2dc, bus.err_arb2dc}) dc_active++;
        if (bus.err_arb2ic) ic_err++;
        if (bus.err_arb2dc) dc_err++;
        bus.ack_mem2arb = 1'b0;
        bus.dat_mem2arb = $urandom;
        if (mem_spurious) begin
            bus.ack_mem2arb = 1'b1;
        end else if (mem_en && bus.req_arb2mem) begin
            if (mem_alt) begin
                go = alt_phase;
                alt_phase = ~alt_phase;
            end else begin
                go = ($urandom_range(99) < ack_pct);
            end
            if (go) begin
                d = mem_fixed ? 32'hFFFF_FFFF : $urandom;
                bus.ack_mem2arb = 1'b1;
                bus.dat_mem2arb = d;
                mem_adr.push_back(bus.adr_arb2mem);
                mem_dat.push_back(d);
            end
        end
    endtask

    task automatic clear_obs();
        ic_obs.delete(); dc_obs.delete(); mem_adr.delete(); mem_dat.delete();
        ic_active = 0; dc_active = 0; ic_err = 0; dc_err = 0;
    endtask

    task automatic drive_idle();
        bus.req_ic2arb = 1'b0; bus.adr_ic2arb = '0;
        bus.req_dc2arb = 1'b0; bus.adr_dc2arb = '0;
        bus.ack_mem2arb = 1'b0; bus.dat_mem2arb = '0;
        mem_en = 0; mem_alt = 0; mem_fixed = 0; mem_spurious = 0; alt_phase = 1; ack_pct = 100;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_obs();
    endtask

    // Bounded wait until the requested number of words has been returned
    task automatic run_until(input int n_ic, input int n_dc, input int budget, output bit ok);
        int c = 0;
        while ((ic_obs.size() < n_ic || dc_obs.size() < n_dc) && c < budget) begin
            tick();
            c++;
        end
        ok = (ic_obs.size() >= n_ic) && (dc_obs.size() >= n_dc);
    endtask

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return (a >> (WO + 2)) << (WO + 2);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        tick(); tick();
        checks++;
        if ({bus.ack_arb2ic, bus.dat_arb2ic, bus.word_arb2ic, bus.last_arb2ic, bus.err_arb2ic,
             bus.ack_arb2dc, bus.dat_arb2dc, bus.word_arb2dc, bus.last_arb2dc, bus.err_arb2dc,
             bus.req_arb2mem, bus.adr_arb2mem} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req_mem=%b adr_mem=%h ack_ic=%b ack_dc=%b, want all zero",
                     bus.req_arb2mem, bus.adr_arb2mem, bus.ack_arb2ic, bus.ack_arb2dc);
        end
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (bus.req_arb2mem !== 1'b0 || ic_obs.size() != 0 || dc_obs.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got req_mem=%b ic_words=%0d dc_words=%0d, want 0/0/0",
                     bus.req_arb2mem, ic_obs.size(), dc_obs.size());
        end
        clear_obs();
    endtask

    task automatic test_single_burst();
        bit ok;
        mem_en = 1; ack_pct = 100; mem_fixed = 1;
        bus.adr_ic2arb = 32'h0000_1234;
        bus.req_ic2arb = 1'b1;
        run_until(NBEAT, 0, 40, ok);
        checks++;
        if (!ok || bus.req_arb2mem !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got words=%0d req_mem_after_last=%b, want 4 and 0", ic_obs.size(), bus.req_arb2mem);
        end
        for (int k = 0; k < NBEAT; k++) begin
            checks++;
            if (mem_adr[k] !== 32'h0000_1230 + 32'(4 * k)) begin
                errors++;
                $display("FAIL single_adr%0d: got %h, want %h", k, mem_adr[k], 32'h0000_1230 + 32'(4 * k));
            end
            checks++;
            if (ic_obs[k].word !== WO'(k) || ic_obs[k].dat !== 32'hFFFF_FFFF || ic_obs[k].last !== (k == NBEAT - 1)) begin
                errors++;
                $display("FAIL single_beat%0d: got word=%0d dat=%h last=%b, want word=%0d dat=ffffffff last=%b",
                         k, ic_obs[k].word, ic_obs[k].dat, ic_obs[k].last, k, (k == NBEAT - 1));
            end
        end
        checks++;
        if (dc_active != 0) begin
            errors++;
            $display("FAIL single_dc_quiet: got %0d active DC cycles, want 0", dc_active);
        end
        bus.req_ic2arb = 1'b0;
        mem_fixed = 0;
        tick(); tick(); tick();
        clear_obs();
    endtask

    task automatic test_arbitration();
        bit ok;
        apply_reset();
        mem_en = 1; ack_pct = 100;
        bus.adr_ic2arb = $urandom; bus.adr_dc2arb = $urandom;
        bus.req_ic2arb = 1'b1; bus.req_dc2arb = 1'b1;
        run_until(NBEAT, 0, 40, ok);
        checks++;
        if (!ok || dc_obs.size() != 0) begin
            errors++;
            $display("FAIL arb_first_ic: got ic_words=%0d dc_words=%0d, want 4/0", ic_obs.size(), dc_obs.size());
        end
        // IC still holds its request: no further grant may happen
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (dc_obs.size() != 0 || ic_obs.size() != NBEAT || bus.req_arb2mem !== 1'b0) begin
            errors++;
            $display("FAIL arb_hold_rel: got ic=%0d dc=%0d req_mem=%b, want 4/0/0", ic_obs.size(), dc_obs.size(), bus.req_arb2mem);
        end
        bus.req_ic2arb = 1'b0;
        run_until(NBEAT, NBEAT, 40, ok);
        checks++;
        if (!ok || ic_obs.size() != NBEAT) begin
            errors++;
            $display("FAIL arb_then_dc: got ic=%0d dc=%0d, want 4/4", ic_obs.size(), dc_obs.size());
        end
        bus.req_dc2arb = 1'b0;
        tick(); tick();
        clear_obs();
        bus.req_ic2arb = 1'b1; bus.req_dc2arb = 1'b1;
        run_until(NBEAT, 0, 40, ok);
        checks++;
        if (!ok || dc_obs.size() != 0) begin
            errors++;
            $display("FAIL arb_rr_back_ic: got ic=%0d dc=%0d, want 4/0", ic_obs.size(), dc_obs.size());
        end
        bus.req_ic2arb = 1'b0; bus.req_dc2arb = 1'b0;
        tick(); tick(); tick();
        clear_obs();
    endtask

    task automatic test_gaps();
        bit ok;
        mem_en = 1; mem_alt = 1; alt_phase = 1;
        bus.adr_dc2arb = 32'h8000_0040;
        bus.req_dc2arb = 1'b1;
        run_until(0, NBEAT, 60, ok);
        bus.req_dc2arb = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (!ok || dc_obs.size() != NBEAT || ic_active != 0) begin
            errors++;
            $display("FAIL gaps_count: got dc_words=%0d ic_active=%0d, want 4/0", dc_obs.size(), ic_active);
        end
        for (int k = 0; k < NBEAT; k++) begin
            checks++;
            if (mem_adr[k] !== 32'h8000_0040 + 32'(4 * k) || dc_obs[k].word !== WO'(k)
                || dc_obs[k].dat !== mem_dat[k] || dc_obs[k].last !== (k == NBEAT - 1)) begin
                errors++;
                $display("FAIL gaps_beat%0d: got adr=%h word=%0d dat=%h last=%b, want adr=%h word=%0d dat=%h last=%b",
                         k, mem_adr[k], dc_obs[k].word, dc_obs[k].dat, dc_obs[k].last,
                         32'h8000_0040 + 32'(4 * k), k, mem_dat[k], (k == NBEAT - 1));
            end
        end
        mem_alt = 0;
        clear_obs();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        logic [31:0] a;
        mem_en = 1; ack_pct = 100;
        bus.adr_ic2arb = $urandom;
        bus.req_ic2arb = 1'b1;
        run_until(2, 0, 40, ok);
        rst = 1'b1;
        bus.req_ic2arb = 1'b0;
        bus.ack_mem2arb = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.ack_arb2ic, bus.dat_arb2ic, bus.word_arb2ic, bus.last_arb2ic, bus.err_arb2ic,
                    bus.ack_arb2dc, bus.dat_arb2dc, bus.word_arb2dc, bus.last_arb2dc, bus.err_arb2dc,
                    bus.req_arb2mem, bus.adr_arb2mem} !== '0) begin
            errors++;
            $display("FAIL midrst_zero: got started=%b req_mem=%b adr_mem=%h ack_ic=%b, want 1/0/0/0",
                     ok, bus.req_arb2mem, bus.adr_arb2mem, bus.ack_arb2ic);
        end
        tick();
        rst = 1'b0;
        clear_obs();
        a = $urandom;
        bus.adr_ic2arb = a;
        bus.req_ic2arb = 1'b1;
        run_until(NBEAT, 0, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_restart: got %0d words, want 4", ic_obs.size());
        end
        for (int k = 0; k < NBEAT; k++) begin
            checks++;
            if (mem_adr[k] !== line_base(a) + 32'(4 * k) || ic_obs[k].word !== WO'(k) || ic_obs[k].dat !== mem_dat[k]) begin
                errors++;
                $display("FAIL midrst_beat%0d: got adr=%h word=%0d dat=%h, want adr=%h word=%0d dat=%h",
                         k, mem_adr[k], ic_obs[k].word, ic_obs[k].dat, line_base(a) + 32'(4 * k), k, mem_dat[k]);
            end
        end
        bus.req_ic2arb = 1'b0;
        tick(); tick(); tick();
        clear_obs();
    endtask

    task automatic test_spurious_ack();
        bit ok;
        mem_en = 0; mem_spurious = 1;
        for (int i = 0; i < 6; i++) tick();
        mem_spurious = 0;
        tick();
        checks++;
        if (ic_active != 0 || dc_active != 0 || bus.req_arb2mem !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: got ic_active=%0d dc_active=%0d req_mem=%b, want 0/0/0", ic_active, dc_active, bus.req_arb2mem);
        end
        mem_en = 1; ack_pct = 50;
        bus.adr_dc2arb = $urandom;
        bus.req_dc2arb = 1'b1;
        run_until(0, NBEAT, 100, ok);
        bus.req_dc2arb = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (!ok || dc_obs.size() != NBEAT || ic_obs.size() != 0 || dc_obs[NBEAT - 1].last !== 1'b1) begin
            errors++;
            $display("FAIL spurious_burst: got dc=%0d ic=%0d, want 4/0 with last on final", dc_obs.size(), ic_obs.size());
        end
        clear_obs();
    endtask

    // Random requesters, addresses, ack density and mid-burst release against a round-robin model
    task automatic test_back_to_back();
        bit ok, favour_dc, exp_dc, drop;
        int sel;
        logic [31:0] a_ic, a_dc, a_own;
        beat_t got[$];
        apply_reset();
        favour_dc = 0;
        for (int it = 0; it < 20; it++) begin
            sel = $urandom_range(2);
            a_ic = $urandom; a_dc = $urandom;
            exp_dc = (sel == 1) || (sel == 2 && favour_dc);
            favour_dc = !exp_dc;
            a_own = exp_dc ? a_dc : a_ic;
            drop = ($urandom_range(1) == 1);
            ack_pct = $urandom_range(100, 25);
            mem_en = 1;
            bus.adr_ic2arb = a_ic; bus.adr_dc2arb = a_dc;
            bus.req_ic2arb = (sel != 1); bus.req_dc2arb = (sel != 0);
            if (drop) begin
                run_until(exp_dc ? 0 : 1, exp_dc ? 1 : 0, 100, ok);
                bus.req_ic2arb = 1'b0; bus.req_dc2arb = 1'b0;
                bus.adr_ic2arb = $urandom; bus.adr_dc2arb = $urandom;
            end
            run_until(exp_dc ? 0 : NBEAT, exp_dc ? NBEAT : 0, 200, ok);
            bus.req_ic2arb = 1'b0; bus.req_dc2arb = 1'b0;
            tick(); tick(); tick();
            if (exp_dc) got = dc_obs; else got = ic_obs;
            checks++;
            if (!ok || got.size() != NBEAT || (exp_dc ? ic_obs.size() : dc_obs.size()) != 0) begin
                errors++;
                $display("FAIL b2b_owner it%0d: got ic=%0d dc=%0d, want owner %s with 4 words only",
                         it, ic_obs.size(), dc_obs.size(), exp_dc ? "DC" : "IC");
            end
            for (int k = 0; k < NBEAT; k++) begin
                checks++;
                if (mem_adr[k] !== line_base(a_own) + 32'(4 * k) || got[k].word !== WO'(k)
                    || got[k].dat !== mem_dat[k] || got[k].last !== (k == NBEAT - 1)) begin
                    errors++;
                    $display("FAIL b2b_beat it%0d k%0d: got adr=%h word=%0d dat=%h last=%b, want adr=%h word=%0d dat=%h last=%b",
                             it, k, mem_adr[k], got[k].word, got[k].dat, got[k].last,
                             line_base(a_own) + 32'(4 * k), k, mem_dat[k], (k == NBEAT - 1));
                end
            end
            clear_obs();
        end
        mem_en = 0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy_cyc = 0;
        int c = 0;
        apply_reset();
        mem_en = 0;
        bus.adr_ic2arb = $urandom;
        bus.req_ic2arb = 1'b1;
        while (ic_err == 0 && c < 50) begin
            tick();
            if (bus.req_arb2mem) busy_cyc++;
            c++;
        end
        checks++;
        if (ic_err != 1 || busy_cyc != 8 || bus.req_arb2mem !== 1'b0 || ic_obs.size() != 0) begin
            errors++;
            $display("FAIL timeout_err: got err=%0d busy=%0d req_mem=%b acks=%0d, want 1/8/0/0",
                     ic_err, busy_cyc, bus.req_arb2mem, ic_obs.size());
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ic_err != 1 || bus.req_arb2mem !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rel: got err=%0d req_mem=%b, want 1/0", ic_err, bus.req_arb2mem);
        end
        bus.req_ic2arb = 1'b0;
        tick(); tick();
        bus.req_dc2arb = 1'b1;
        tick(); tick();
        checks++;
        if (bus.req_arb2mem !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle: got req_mem=%b, want 1 after new grant", bus.req_arb2mem);
        end
        bus.req_dc2arb = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_obs();
    endtask
`endif

    initial begin
        clear_obs();
        test_reset();
        test_single_burst();
        test_arbitration();
        test_gaps();
        test_reset_mid_burst();
        test_spurious_ack();
        test_back_to_back();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
